param_alu_seq: RTL

PARAM_ALU_SEQ -- requirements
Module: param_alu_seq

---
 rtl/param_alu_pkg.sv | 28 ++
 rtl/param_alu_core.sv | 64 ++++++
 rtl/param_alu_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/param_alu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// param_alu_pkg : opcodes, FSM state type and opcode helpers
// Revision: 1.0
// ------------------------------------------------------------------
package param_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_BNE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_ASR) || (op == OP_SHL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/param_alu_core.sv
`default_nettype none
// ------------------------------------------------------------------
// param_alu_core : single-cycle ALU ops and flag generation
// Revision: 1.0
// ------------------------------------------------------------------
module param_alu_core
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             zero,
    output logic             take_branch
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_sum_ovf;
    logic             w_diff_ovf;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign w_sum_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
    assign w_diff_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        f           = '0;
        ovf         = 1'b0;
        take_branch = 1'b0;
        case (sel)
            OP_ADD: begin
                f   = w_sum;
                ovf = w_sum_ovf;
            end
            OP_SUB: begin
                f   = w_diff;
                ovf = w_diff_ovf;
            end
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_BEQ: begin
                f           = w_diff;
                ovf         = w_diff_ovf;
                take_branch = (a == b);
            end
            OP_BNE: begin
                f           = w_diff;
                ovf         = w_diff_ovf;
                take_branch = (a != b);
            end
            default: ;
        endcase
    end

    assign zero = (f == '0);

endmodule
`default_nettype wire

// File: rtl/param_alu_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// param_alu_seq : handshaked ALU, shifts sequenced one bit per cycle
// Revision: 1.0
// ------------------------------------------------------------------
module param_alu_seq
    import param_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             zero,
    output logic             take_branch
);

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_f;
    logic             r_ovf;
    logic             r_zero;
    logic             r_tb;
    logic [SHW-1:0]   r_cnt;
    logic             r_asr;

    logic [WIDTH-1:0] w_core_f;
    logic             w_core_ovf;
    logic             w_core_zero;
    logic             w_core_tb;
    logic             w_accept;
    logic             w_shift_op;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last_shift;

    param_alu_core #(.WIDTH(WIDTH)) u_core (
        .a           (a),
        .b           (b),
        .sel         (sel),
        .f           (w_core_f),
        .ovf         (w_core_ovf),
        .zero        (w_core_zero),
        .take_branch (w_core_tb)
    );

    assign w_accept     = in_valid && in_ready;
    assign w_shift_op   = is_shift_op(sel);
    assign w_amt        = b[SHW-1:0];
    assign w_shifted    = r_asr ? {r_f[WIDTH-1], r_f[WIDTH-1:1]} : {r_f[WIDTH-2:0], 1'b0};
    assign w_last_shift = (r_cnt == SHW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_shift_op && (w_amt != '0)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last_shift) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The accept edge loads the operand; each SHIFT cycle moves it one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f    <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_tb   <= 1'b0;
            r_cnt  <= '0;
            r_asr  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_asr <= (sel == OP_ASR);
                        r_cnt <= w_amt;
                        if (w_shift_op) begin
                            r_f    <= a;
                            r_ovf  <= 1'b0;
                            r_zero <= (a == '0);
                            r_tb   <= 1'b0;
                        end else begin
                            r_f    <= w_core_f;
                            r_ovf  <= w_core_ovf;
                            r_zero <= w_core_zero;
                            r_tb   <= w_core_tb;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_f   <= w_shifted;
                    r_cnt <= r_cnt - SHW'(1);
                    if (w_last_shift) begin
                        r_zero <= (w_shifted == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign f           = r_f;
    assign ovf         = r_ovf;
    assign zero        = r_zero;
    assign take_branch = r_tb;

endmodule
`default_nettype wire
